// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU: fetch/decode/execute/writeback
// sequencing, instruction register, flag register and all datapath controls.
module cpu_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [4:0]  alu_flags,
    output logic [15:0] opcode,
    output logic [3:0]  mux_a_sel,
    output logic [3:0]  mux_b_sel,
    output logic        alu_sel,
    output logic        pc_sel,
    output logic        w_en_a,
    output logic [15:0] reg_en,
    output logic        flag_en,
    output logic        pc_en,
    output logic        pc_ld,
    output logic [4:0]  flags_q,
    output logic [1:0]  state_dbg
);

    // Handshake-free block: instr is sampled in DECODE, one cycle after FETCH
    // presents the PC address; alu_flags is sampled on the EXEC edge of ALU ops.

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        LDWB   = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [15:0] ir;

    logic [3:0] op, rd, ext, rs;
    logic       is_alu, is_cmp, is_load, is_stor, is_jcond;
    logic       cond;

    assign op  = ir[15:12];
    assign rd  = ir[11:8];
    assign ext = ir[7:4];
    assign rs  = ir[3:0];

    assign opcode    = ir;
    assign state_dbg = state;

    always_comb begin
        is_alu   = 1'b0;
        is_cmp   = 1'b0;
        is_load  = 1'b0;
        is_stor  = 1'b0;
        is_jcond = 1'b0;
        case (op)
            4'b0000: begin
                is_alu = (ext != 4'b0100) && (ext != 4'b1100);
                is_cmp = (ext == 4'b1011);
            end
            4'b0001, 4'b0010, 4'b0011, 4'b0101,
            4'b1001, 4'b1101, 4'b1111: is_alu = 1'b1;
            4'b1011: begin
                is_alu = 1'b1;
                is_cmp = 1'b1;
            end
            4'b0100: begin
                is_load  = (ext == 4'b0000);
                is_stor  = (ext == 4'b0100);
                is_jcond = (ext == 4'b1100);
            end
            default: ;
        endcase
    end

    // Flag layout {C,L,F,Z,N}: C = [4], Z = [1], N = [0].
    always_comb begin
        cond = 1'b0;
        case (rd)
            4'b0000: cond = flags_q[1];
            4'b0001: cond = !flags_q[1];
            4'b0010: cond = flags_q[4];
            4'b0011: cond = !flags_q[4];
            4'b0110: cond = flags_q[0];
            4'b0111: cond = !flags_q[0];
            4'b1100: cond = !flags_q[0] && !flags_q[1];
            4'b1101: cond = flags_q[0] || flags_q[1];
            4'b1110: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            ir      <= 16'h0000;
            flags_q <= 5'b00000;
        end else begin
            state <= state_next;
            if (state == DECODE)
                ir <= instr;
            if (state == EXEC && is_alu)
                flags_q <= alu_flags;
        end
    end

    always_comb begin
        state_next = FETCH;
        mux_a_sel  = 4'h0;
        mux_b_sel  = 4'h0;
        alu_sel    = 1'b1;
        pc_sel     = 1'b1;
        w_en_a     = 1'b0;
        reg_en     = 16'h0000;
        flag_en    = 1'b0;
        pc_en      = 1'b0;
        pc_ld      = 1'b0;
        // Reset forces the FETCH output pattern so an aborted instruction
        // cannot write memory, the register file or the PC on that edge.
        if (!reset) begin
            case (state)
                FETCH:  state_next = DECODE;
                DECODE: state_next = EXEC;
                EXEC: begin
                    state_next = FETCH;
                    if (is_alu) begin
                        mux_a_sel = rd;
                        mux_b_sel = rs;
                        reg_en    = is_cmp ? 16'h0000 : (16'h0001 << rd);
                        flag_en   = 1'b1;
                        pc_en     = 1'b1;
                    end else if (is_load) begin
                        pc_sel     = 1'b0;
                        mux_a_sel  = rs;
                        state_next = LDWB;
                    end else if (is_stor) begin
                        pc_sel    = 1'b0;
                        mux_a_sel = rs;
                        mux_b_sel = rd;
                        w_en_a    = 1'b1;
                        pc_en     = 1'b1;
                    end else if (is_jcond) begin
                        mux_a_sel = rs;
                        pc_en     = 1'b1;
                        pc_ld     = cond;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                LDWB: begin
                    state_next = FETCH;
                    pc_sel     = 1'b0;
                    mux_a_sel  = rs;
                    alu_sel    = 1'b0;
                    reg_en     = 16'h0001 << rd;
                    pc_en      = 1'b1;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: hand-written vector table, reset
// abort sequence and randomized instructions against an instruction-level model.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [4:0]  alu_flags;
    logic [15:0] opcode;
    logic [3:0]  mux_a_sel, mux_b_sel;
    logic        alu_sel, pc_sel, w_en_a, flag_en, pc_en, pc_ld;
    logic [15:0] reg_en;
    logic [4:0]  flags_q;
    logic [1:0]  state_dbg;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
        .opcode(opcode), .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel),
        .alu_sel(alu_sel), .pc_sel(pc_sel), .w_en_a(w_en_a), .reg_en(reg_en),
        .flag_en(flag_en), .pc_en(pc_en), .pc_ld(pc_ld), .flags_q(flags_q),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] opc;
        logic [3:0]  ma;
        logic [3:0]  mb;
        logic        alu_s;
        logic        pc_s;
        logic        wen;
        logic [15:0] ren;
        logic        fen;
        logic        pen;
        logic        pld;
        logic [4:0]  fq;
    } out_t;

    typedef struct packed {
        logic [15:0] w;
        logic [4:0]  af;
        logic [3:0]  ma;
        logic [3:0]  mb;
        logic        pc_s;
        logic        wen;
        logic [15:0] ren;
        logic        fen;
        logic        pld;
    } tab_t;

    out_t act;
    assign act = {state_dbg, opcode, mux_a_sel, mux_b_sel, alu_sel, pc_sel,
                  w_en_a, reg_en, flag_en, pc_en, pc_ld, flags_q};

    int          vecs  = 0;
    int          fails = 0;
    logic [15:0] m_ir  = 16'h0000;
    logic [4:0]  m_fq  = 5'b00000;
    out_t        exp_q[$];

    task automatic check(input string name, input out_t exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: instr=%h got=%h want=%h", name, m_ir, act, exp);
        end
    endtask

    // Phase: 0 fetch, 1 decode, 2 exec, 3 load writeback.
    function automatic out_t idle_rec(input logic [1:0] st, input logic [15:0] ir,
                                      input logic [4:0] fq);
        out_t r;
        r = '0;
        r.st = st; r.opc = ir; r.fq = fq;
        r.alu_s = 1'b1; r.pc_s = 1'b1;
        return r;
    endfunction

    // Instruction class: 0 ALU, 1 LOAD, 2 STOR, 3 JCOND, 4 NOP.
    function automatic int iclass(input logic [15:0] w);
        int alu_ops[8] = '{1, 2, 3, 5, 9, 11, 13, 15};
        int op  = int'(w[15:12]);
        int ext = int'(w[7:4]);
        if (op == 0) return (ext == 4 || ext == 12) ? 4 : 0;
        foreach (alu_ops[i]) if (alu_ops[i] == op) return 0;
        if (op == 4) begin
            if (ext == 0)  return 1;
            if (ext == 4)  return 2;
            if (ext == 12) return 3;
        end
        return 4;
    endfunction

    function automatic logic cond_of(input logic [3:0] rd, input logic [4:0] fq);
        logic c = fq[4], z = fq[1], n = fq[0];
        case (rd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd6:  return n;
            4'd7:  return !n;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Builds the full cycle-by-cycle output sequence of one instruction.
    task automatic model_instr(input logic [15:0] w, input logic [4:0] af);
        out_t e;
        logic [3:0] rd = w[11:8], rs = w[3:0];
        logic is_cmp = (w[15:12] == 4'hB) || (w[15:12] == 4'h0 && w[7:4] == 4'hB);
        exp_q.push_back(idle_rec(2'd0, m_ir, m_fq));
        exp_q.push_back(idle_rec(2'd1, m_ir, m_fq));
        e = idle_rec(2'd2, w, m_fq);
        case (iclass(w))
            0: begin
                e.ma = rd; e.mb = rs; e.fen = 1'b1; e.pen = 1'b1;
                e.ren = is_cmp ? 16'h0 : 16'(1 << rd);
            end
            1: begin e.pc_s = 1'b0; e.ma = rs; end
            2: begin e.pc_s = 1'b0; e.ma = rs; e.mb = rd; e.wen = 1'b1; e.pen = 1'b1; end
            3: begin e.ma = rs; e.pen = 1'b1; e.pld = cond_of(rd, m_fq); end
            default: e.pen = 1'b1;
        endcase
        exp_q.push_back(e);
        if (iclass(w) == 0) m_fq = af;
        if (iclass(w) == 1) begin
            e = idle_rec(2'd3, w, m_fq);
            e.pc_s = 1'b0; e.ma = rs; e.alu_s = 1'b0; e.ren = 16'(1 << rd); e.pen = 1'b1;
            exp_q.push_back(e);
        end
        m_ir = w;
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the next FETCH.
    task automatic run_instr(input logic [15:0] w, input logic [4:0] af,
                             input logic use_tab, input tab_t tv);
        out_t t;
        logic [4:0] fq_exec = m_fq;
        int n = 0;
        instr = w; alu_flags = af;
        model_instr(w, af);
        while (exp_q.size() > 0) begin
            if (n > 0) @(negedge clk);
            #1;
            check($sformatf("cycle%0d", n), exp_q.pop_front());
            if (n == 2 && use_tab) begin
                t = idle_rec(2'd2, w, fq_exec);
                t.ma = tv.ma; t.mb = tv.mb; t.pc_s = tv.pc_s; t.wen = tv.wen;
                t.ren = tv.ren; t.fen = tv.fen; t.pld = tv.pld;
                t.pen = (iclass(w) != 1);
                check("table_exec", t);
            end
            n++;
        end
        @(negedge clk);
    endtask

    tab_t tab[14];
    tab_t none;

    initial begin
        none = '0;
        //            w        af        ma  mb  pcs wen ren      fen pld
        tab[0]  = '{16'h0355, 5'b00000, 4'd3, 4'd5, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0};
        tab[1]  = '{16'h01B2, 5'b00010, 4'd1, 4'd2, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tab[2]  = '{16'h40C7, 5'b00000, 4'd7, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tab[3]  = '{16'h41CA, 5'b00000, 4'hA, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab[4]  = '{16'h4409, 5'b11111, 4'd9, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab[5]  = '{16'h4642, 5'b11111, 4'd2, 4'd6, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        tab[6]  = '{16'h4A30, 5'b11111, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab[7]  = '{16'hB123, 5'b10001, 4'd1, 4'd3, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tab[8]  = '{16'h4CC4, 5'b00000, 4'd4, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab[9]  = '{16'h4DC4, 5'b00000, 4'd4, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tab[10] = '{16'h4EC0, 5'b00000, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tab[11] = '{16'h0045, 5'b11111, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab[12] = '{16'hF7E1, 5'b00000, 4'd7, 4'd1, 1'b1, 1'b0, 16'h0080, 1'b1, 1'b0};
        tab[13] = '{16'h4FC0, 5'b11111, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

        reset = 1'b1; instr = 16'h0000; alu_flags = 5'b00000;
        repeat (3) @(negedge clk);
        #1 check("reset_idle", idle_rec(2'd0, 16'h0000, 5'b00000));
        reset = 1'b0;

        // Load nonzero flags, then abort an ADD in EXEC with two reset cycles.
        run_instr(16'h01B2, 5'b00110, 1'b0, none);
        instr = 16'h0355; alu_flags = 5'b11111;
        #1 check("abort_fetch", idle_rec(2'd0, m_ir, m_fq));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("abort_in_exec", idle_rec(2'd2, 16'h0355, m_fq));
        @(negedge clk);
        #1 check("abort_hold", idle_rec(2'd0, 16'h0000, 5'b00000));
        @(negedge clk);
        reset = 1'b0;
        m_ir = 16'h0000; m_fq = 5'b00000;

        foreach (tab[i]) run_instr(tab[i].w, tab[i].af, 1'b1, tab[i]);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                w[15:12] = 4'h4;
                case ($urandom_range(0, 3))
                    0: w[7:4] = 4'h0;
                    1: w[7:4] = 4'h4;
                    2: w[7:4] = 4'hC;
                    default: ;
                endcase
            end
            run_instr(w, 5'($urandom), 1'b0, none);
        end
        #1 check("final_fetch", idle_rec(2'd0, m_ir, m_fq));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
